// File: rtl/readout_frame_scheduler_pkg.sv
// Shared definitions for the readout frame scheduler: one-hot state codes and timing helpers.
// Timer reload values are "cycles minus one" so a zero flag marks the final cycle of a window.
package readout_frame_scheduler_pkg;

    localparam logic [31:0] ST_IDLE    = 32'h0000_0001;
    localparam logic [31:0] ST_EXPOSE  = 32'h0000_0002;
    localparam logic [31:0] ST_TRIG    = 32'h0000_0004;
    localparam logic [31:0] ST_WAIT_LO = 32'h0000_0008;
    localparam logic [31:0] ST_GAP     = 32'h0000_0010;

    localparam logic [31:0] DEFAULT_T_TIMEOUT = 32'd1024;

    typedef enum logic [31:0] {
        S_idle    = ST_IDLE,
        S_expose  = ST_EXPOSE,
        S_trig    = ST_TRIG,
        S_wait_lo = ST_WAIT_LO,
        S_gap     = ST_GAP
    } state_t;

    // A window of t cycles (t=0 behaves as 1) reloads the down-counter with t-1.
    function automatic logic [31:0] load_of(input logic [31:0] t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/readout_frame_scheduler_frame_timer.sv
// Loadable 32-bit down-counter; zero is high once the count reaches 0 and it then holds there.
// Latency: a load takes effect on the next edge; no backpressure.
module frame_timer (
    input  logic        TX_CLK,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        zero
);

    logic [31:0] cnt;

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
        end
    end

    assign zero = (cnt == 32'd0);

endmodule

// File: rtl/readout_frame_scheduler.sv
// Sequences expose -> trigger handshake -> readout -> gap frames; outputs registered, EXPOSE/trigger_o lag state by one cycle.
// Backpressure: trigger_o is held until re_busy rises, and a stop never truncates a readout in progress.
module readout_frame_scheduler
    import readout_frame_scheduler_pkg::*;
(
    input  logic        TX_CLK,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [31:0] NUM_FRAMES,
    input  logic [31:0] T_EXPOSE,
    input  logic [31:0] T_GAP,
    input  logic [31:0] T_TIMEOUT,
    input  logic        re_busy,
    output logic        trigger_o,
    output logic        EXPOSE,
    output logic        sched_busy,
    output logic [31:0] frame_cnt,
    output logic        seq_done,
    output logic        timeout_err
);

    state_t      state, state_nxt;
    logic        stop_pend, to_en, cont_q;
    logic [31:0] num_frames_q;
    logic        tmr_load, tmr_zero;
    logic [31:0] tmr_val;
    logic        done_nxt, start_seq, empty_seq, frame_done, timed_out;
    logic [31:0] cnt_next;

    assign cnt_next = frame_cnt + 32'd1;

    frame_timer u_timer (
        .TX_CLK   (TX_CLK),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        done_nxt   = 1'b0;
        start_seq  = 1'b0;
        empty_seq  = 1'b0;
        frame_done = 1'b0;
        timed_out  = 1'b0;
        case (state)
            S_idle: begin
                if (start && !stop) begin
                    if (!continuous && NUM_FRAMES == 32'd0) begin
                        empty_seq = 1'b1;
                        done_nxt  = 1'b1;
                    end else begin
                        start_seq = 1'b1;
                        state_nxt = S_expose;
                        tmr_load  = 1'b1;
                        tmr_val   = load_of(T_EXPOSE);
                    end
                end
            end
            S_expose: begin
                if (stop) begin
                    state_nxt = S_idle;
                    done_nxt  = 1'b1;
                end else if (tmr_zero) begin
                    state_nxt = S_trig;
                    tmr_load  = 1'b1;
                    tmr_val   = load_of(T_TIMEOUT);
                end
            end
            S_trig: begin
                if (re_busy) begin
                    state_nxt = S_wait_lo;
                end else if (to_en && tmr_zero) begin
                    state_nxt = S_idle;
                    timed_out = 1'b1;
                end
            end
            S_wait_lo: begin
                if (!re_busy) begin
                    frame_done = 1'b1;
                    if ((!cont_q && cnt_next == num_frames_q) || stop_pend || stop) begin
                        state_nxt = S_idle;
                        done_nxt  = 1'b1;
                    end else if (T_GAP == 32'd0) begin
                        state_nxt = S_expose;
                        tmr_load  = 1'b1;
                        tmr_val   = load_of(T_EXPOSE);
                    end else begin
                        state_nxt = S_gap;
                        tmr_load  = 1'b1;
                        tmr_val   = load_of(T_GAP);
                    end
                end
            end
            S_gap: begin
                if (stop) begin
                    state_nxt = S_idle;
                    done_nxt  = 1'b1;
                end else if (tmr_zero) begin
                    state_nxt = S_expose;
                    tmr_load  = 1'b1;
                    tmr_val   = load_of(T_EXPOSE);
                end
            end
            default: state_nxt = S_idle;
        endcase
    end

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_idle;
            trigger_o    <= 1'b0;
            EXPOSE       <= 1'b0;
            sched_busy   <= 1'b0;
            seq_done     <= 1'b0;
            timeout_err  <= 1'b0;
            frame_cnt    <= '0;
            stop_pend    <= 1'b0;
            to_en        <= 1'b0;
            cont_q       <= 1'b0;
            num_frames_q <= '0;
        end else begin
            state      <= state_nxt;
            trigger_o  <= (state == S_trig);
            EXPOSE     <= (state == S_expose);
            sched_busy <= (state_nxt != S_idle);
            seq_done   <= done_nxt;
            if (start_seq || empty_seq) begin
                frame_cnt    <= '0;
                timeout_err  <= 1'b0;
                cont_q       <= continuous;
                num_frames_q <= NUM_FRAMES;
            end else begin
                if (frame_done) frame_cnt <= cnt_next;
                if (timed_out) timeout_err <= 1'b1;
            end
            // A stop seen mid-handshake is remembered until the readout finishes.
            if (state_nxt == S_idle) begin
                stop_pend <= 1'b0;
            end else if (stop && (state == S_trig || state == S_wait_lo)) begin
                stop_pend <= 1'b1;
            end
            if (state_nxt == S_trig && state != S_trig) begin
                to_en <= (T_TIMEOUT != 32'd0);
            end
        end
    end

endmodule
